// File: rtl/fpadd_disp_pkg.sv
// Shared constants for the FP result display: hex glyph table, byte index width
// and the output polarity helper.
package fpadd_disp_pkg;

    localparam int BYTE_IDX_W = 2;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}, indexed by nibble.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [8:0] apply_pol(input logic [8:0] value, input logic active_low);
        return active_low ? ~value : value;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment decoder, active-high {g,f,e,d,c,b,a}.
module hex_to_seg7
    import fpadd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/fp_result_display.sv
// Captures each FP sum and shows it byte by byte (MSB first) on LEDs and two
// multiplexed hex digits, with per-byte dwell and digit-enable refresh.
module fp_result_display
    import fpadd_disp_pkg::*;
#(
    parameter int DWELL_CYCLES   = 100_000_000,
    parameter int REFRESH_CYCLES = 100_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        result_valid,
    input  logic [31:0] result,
    output logic [7:0]  leds,
    output logic [1:0]  byte_idx,
    output logic        an0,
    output logic        a0, b0, c0, d0, e0, f0, g0,
    output logic        fp0,
    output logic        an1,
    output logic        a1, b1, c1, d1, e1, f1, g1,
    output logic        fp1
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [31:0]           hold;
    logic [BYTE_IDX_W-1:0] idx;
    logic [DW-1:0]         dwell_cnt;
    logic [RW-1:0]         refresh_cnt;
    logic                  phase;
    logic                  phase_next;
    logic                  dwell_done;
    logic                  refresh_wrap;
    logic [7:0]            cur_byte;
    logic [6:0]            seg_hi;
    logic [6:0]            seg_lo;
    logic [7:0]            leds_q;
    logic [1:0]            idx_q;
    logic [8:0]            disp1_q;
    logic [8:0]            disp0_q;

    assign dwell_done   = (dwell_cnt == DW'(DWELL_CYCLES - 1));
    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_CYCLES - 1));
    assign phase_next   = phase ^ refresh_wrap;
    assign cur_byte     = hold[8*idx +: 8];

    hex_to_seg7 u_seg_hi (.nibble(cur_byte[7:4]), .seg(seg_hi));
    hex_to_seg7 u_seg_lo (.nibble(cur_byte[3:0]), .seg(seg_lo));

    // A load always wins over dwell expiry so a fresh sum starts at its top byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            idx       <= 2'd3;
            dwell_cnt <= '0;
        end else if (result_valid) begin
            hold      <= result;
            idx       <= 2'd3;
            dwell_cnt <= '0;
        end else if (dwell_done) begin
            idx       <= idx - 2'd1;
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            phase       <= 1'b0;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
            phase       <= phase_next;
        end
    end

    // Each digit register packs {an, fp, g..a}; anodes follow the phase without extra lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q  <= 8'h00;
            idx_q   <= 2'd3;
            disp1_q <= apply_pol({1'b0, 1'b1, HEX_SEG[0]}, SEG_ACTIVE_LOW);
            disp0_q <= apply_pol({1'b1, 1'b0, HEX_SEG[0]}, SEG_ACTIVE_LOW);
        end else begin
            leds_q  <= cur_byte;
            idx_q   <= idx;
            disp1_q <= apply_pol({phase_next, idx == 2'd3, seg_hi}, SEG_ACTIVE_LOW);
            disp0_q <= apply_pol({~phase_next, idx == 2'd0, seg_lo}, SEG_ACTIVE_LOW);
        end
    end

    assign leds     = leds_q;
    assign byte_idx = idx_q;
    assign {an1, fp1, g1, f1, e1, d1, c1, b1, a1} = disp1_q;
    assign {an0, fp0, g0, f0, e0, d0, c0, b0, a0} = disp0_q;

endmodule
